// File: rtl/topview_line_reader_if.sv
// Output segment stream from the topview line reader to the path planner.
// The producer owns valid and the segment fields; the consumer owns ready.
interface topview_line_reader_if #(
    parameter int V_W    = 8,
    parameter int H_W    = 9,
    parameter int ADDR_W = 12
);
    logic              m_valid;
    logic              m_ready;
    logic [V_W-1:0]    m_start_v;
    logic [H_W-1:0]    m_start_h;
    logic [V_W-1:0]    m_end_v;
    logic [H_W-1:0]    m_end_h;
    logic              m_seg_valid;
    logic [ADDR_W-1:0] m_index;

    modport master (
        output m_valid, m_start_v, m_start_h, m_end_v, m_end_h, m_seg_valid, m_index,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_start_v, m_start_h, m_end_v, m_end_h, m_seg_valid, m_index,
        output m_ready
    );
endinterface

// File: rtl/topview_line_reader.sv
// Drains the topview segment BRAM once per frame into a 2-entry output buffer,
// issuing reads only when the buffer has room for the data they will return.
//
// state | meaning
// IDLE  | waiting for a rising edge of tv_ready
// READ  | issuing BRAM reads while credit allows
// DRAIN | no more reads; wait for in-flight data and buffer to empty
module topview_line_reader #(
    parameter int OUT_HEIGHT   = 240,
    parameter int OUT_WIDTH    = 320,
    parameter int ADDR_W       = 12,
    parameter bit SKIP_INVALID = 1'b1,
    localparam int V_W = $clog2(OUT_HEIGHT),
    localparam int H_W = $clog2(OUT_WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tv_ready,
    input  logic [ADDR_W-1:0] tv_line_num,
    output logic [ADDR_W-1:0] tv_raddr,
    input  logic [V_W-1:0]    tv_start_v,
    input  logic [V_W-1:0]    tv_end_v,
    input  logic [H_W-1:0]    tv_start_h,
    input  logic [H_W-1:0]    tv_end_h,
    input  logic              tv_valid,
    topview_line_reader_if.master m,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_abort,
    output logic [ADDR_W-1:0] lines_out
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [V_W-1:0]    sv;
        logic [H_W-1:0]    sh;
        logic [V_W-1:0]    ev;
        logic [H_W-1:0]    eh;
        logic              segv;
    } entry_t;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              tv_ready_q;
    logic [ADDR_W-1:0] count_q, rd_addr_q, infl_addr_q, acc_q, lines_q;
    logic              inflight_q, abort_q, done_q, abort_p_q;
    entry_t            head_q, tail_q, push_e;
    logic              head_v_q, tail_v_q;
    logic              rise, fall, pop, push, issue, frame_end;
    logic [1:0]        occ;
    logic [2:0]        credit;

    assign rise   = tv_ready & ~tv_ready_q;
    assign fall   = ~tv_ready & tv_ready_q;
    assign pop    = head_v_q & m.m_ready;
    assign push   = inflight_q & (tv_valid | ~SKIP_INVALID);
    assign push_e = '{idx: infl_addr_q, sv: tv_start_v, sh: tv_start_h,
                      ev: tv_end_v, eh: tv_end_h, segv: tv_valid};
    assign occ    = {1'b0, head_v_q} + {1'b0, tail_v_q};
    // Slots that will be occupied after this cycle, before any new issue.
    assign credit = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) state_d = (tv_line_num == '0) ? DRAIN : READ;
            end
            READ: begin
                if (fall) begin
                    state_d = DRAIN;
                end else if (rd_addr_q < count_q) begin
                    if (credit < 3'd2) issue = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight_q && occ == 2'd0) begin
                    frame_end = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tv_ready_q  <= 1'b0;
            count_q     <= '0;
            rd_addr_q   <= '0;
            infl_addr_q <= '0;
            inflight_q  <= 1'b0;
            acc_q       <= '0;
            abort_q     <= 1'b0;
            done_q      <= 1'b0;
            abort_p_q   <= 1'b0;
            lines_q     <= '0;
        end else begin
            tv_ready_q <= tv_ready;
            inflight_q <= issue;
            if (issue) infl_addr_q <= rd_addr_q;
            if (state_q == IDLE && rise) begin
                count_q   <= tv_line_num;
                rd_addr_q <= '0;
                acc_q     <= '0;
                abort_q   <= 1'b0;
            end else begin
                if (issue) rd_addr_q <= rd_addr_q + ONE;
                if (pop)   acc_q     <= acc_q + ONE;
                if (state_q == READ && fall) abort_q <= 1'b1;
            end
            done_q    <= frame_end & ~abort_q;
            abort_p_q <= frame_end & abort_q;
            if (frame_end) lines_q <= acc_q;
        end
    end

    // Head register drives the outputs directly; tail only holds overflow from the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            head_v_q <= 1'b0;
            tail_v_q <= 1'b0;
        end else if (pop) begin
            if (tail_v_q) begin
                head_q   <= tail_q;
                tail_v_q <= push;
                if (push) tail_q <= push_e;
            end else begin
                head_v_q <= push;
                if (push) head_q <= push_e;
            end
        end else if (push) begin
            if (!head_v_q) begin
                head_v_q <= 1'b1;
                head_q   <= push_e;
            end else begin
                tail_v_q <= 1'b1;
                tail_q   <= push_e;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && head_v_q && tail_v_q));

    assign tv_raddr      = rd_addr_q;
    assign busy          = (state_q != IDLE);
    assign frame_done    = done_q;
    assign frame_abort   = abort_p_q;
    assign lines_out     = lines_q;
    assign m.m_valid     = head_v_q;
    assign m.m_index     = head_q.idx;
    assign m.m_start_v   = head_q.sv;
    assign m.m_start_h   = head_q.sh;
    assign m.m_end_v     = head_q.ev;
    assign m.m_end_h     = head_q.eh;
    assign m.m_seg_valid = head_q.segv;
endmodule

// File: tb/tb_topview_line_reader.sv
// Scoreboard bench for topview_line_reader: one DUT dropping invalid entries,
// one forwarding them, both fed from a modelled 1-cycle-latency BRAM.
module tb_topview_line_reader;
    localparam int AW = 12;
    localparam int VW = 8;
    localparam int HW = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          tv_ready   = 1'b0;
    logic          tv_ready_b = 1'b0;
    logic [AW-1:0] line_num   = '0;
    logic          rdy_a      = 1'b1;

    logic [AW-1:0] raddr_a, raddr_b, lines_a, lines_b;
    logic [VW-1:0] sv_a, ev_a, sv_b, ev_b;
    logic [HW-1:0] sh_a, eh_a, sh_b, eh_b;
    logic          vld_a, vld_b;
    logic          busy_a, done_a, abort_a, busy_b, done_b, abort_b;

    topview_line_reader_if #(.V_W(VW), .H_W(HW), .ADDR_W(AW)) ifa ();
    topview_line_reader_if #(.V_W(VW), .H_W(HW), .ADDR_W(AW)) ifb ();
    assign ifa.m_ready = rdy_a;
    assign ifb.m_ready = 1'b1;

    topview_line_reader #(.SKIP_INVALID(1'b1)) dut_a (
        .clk(clk), .rst(rst), .tv_ready(tv_ready), .tv_line_num(line_num),
        .tv_raddr(raddr_a), .tv_start_v(sv_a), .tv_end_v(ev_a),
        .tv_start_h(sh_a), .tv_end_h(eh_a), .tv_valid(vld_a), .m(ifa),
        .busy(busy_a), .frame_done(done_a), .frame_abort(abort_a), .lines_out(lines_a)
    );

    topview_line_reader #(.SKIP_INVALID(1'b0)) dut_b (
        .clk(clk), .rst(rst), .tv_ready(tv_ready_b), .tv_line_num(line_num),
        .tv_raddr(raddr_b), .tv_start_v(sv_b), .tv_end_v(ev_b),
        .tv_start_h(sh_b), .tv_end_h(eh_b), .tv_valid(vld_b), .m(ifb),
        .busy(busy_b), .frame_done(done_b), .frame_abort(abort_b), .lines_out(lines_b)
    );

    logic [VW-1:0] mem_sv [0:127];
    logic [HW-1:0] mem_sh [0:127];
    logic [VW-1:0] mem_ev [0:127];
    logic [HW-1:0] mem_eh [0:127];
    logic          mem_vld[0:127];

    always @(posedge clk) begin
        sv_a  <= mem_sv[raddr_a[6:0]];  sh_a <= mem_sh[raddr_a[6:0]];
        ev_a  <= mem_ev[raddr_a[6:0]];  eh_a <= mem_eh[raddr_a[6:0]];
        vld_a <= mem_vld[raddr_a[6:0]];
        sv_b  <= mem_sv[raddr_b[6:0]];  sh_b <= mem_sh[raddr_b[6:0]];
        ev_b  <= mem_ev[raddr_b[6:0]];  eh_b <= mem_eh[raddr_b[6:0]];
        vld_b <= mem_vld[raddr_b[6:0]];
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] exp_ent(input int i, input logic segv);
        logic [63:0] r;
        r = '0;
        r[46:0] = {AW'(i), mem_sv[i], mem_sh[i], mem_ev[i], mem_eh[i], segv};
        return r;
    endfunction

    logic [63:0] qa[$];
    logic [63:0] qb[$];

    int  first_a, first_pop_a, last_pop_a, pops_a, t_a, done_cyc_a;
    int  n_done_a = 0, n_abort_a = 0, n_done_b = 0, n_abort_b = 0;
    bit  stall_prev = 1'b0;

    logic [63:0] obs_a, obs_b;
    always_comb begin
        obs_a = '0;
        obs_a[46:0] = {ifa.m_index, ifa.m_start_v, ifa.m_start_h, ifa.m_end_v, ifa.m_end_h, ifa.m_seg_valid};
        obs_b = '0;
        obs_b[46:0] = {ifb.m_index, ifb.m_start_v, ifb.m_start_h, ifb.m_end_v, ifb.m_end_h, ifb.m_seg_valid};
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ifa.m_valid && first_a < 0) first_a = cyc;
            if (stall_prev && qa.size() > 0)
                check("stall_hold", {16'd0, ifa.m_valid, obs_a[46:0]}, {16'd0, 1'b1, qa[0][46:0]});
            if (ifa.m_valid && rdy_a) begin
                check("sb_a_avail", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) check("seg_a", obs_a, qa.pop_front());
                if (pops_a == 0) first_pop_a = cyc;
                pops_a++;
                last_pop_a = cyc;
            end
            stall_prev = ifa.m_valid && !rdy_a;
            if (done_a)  begin n_done_a++; done_cyc_a = cyc; end
            if (abort_a) n_abort_a++;
            if (ifb.m_valid) begin
                check("sb_b_avail", 64'(qb.size() != 0), 64'd1);
                if (qb.size() != 0) check("seg_b", obs_b, qb.pop_front());
            end
            if (done_b)  n_done_b++;
            if (abort_b) n_abort_b++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_a(input int n);
        for (int i = 0; i < n; i++)
            if (mem_vld[i]) qa.push_back(exp_ent(i, 1'b1));
        line_num    = AW'(n);
        tv_ready    = 1'b1;
        t_a         = cyc + 1;
        first_a     = -1;
        pops_a      = 0;
        first_pop_a = -1;
    endtask

    task automatic wait_end_a(input string tag, input int budget);
        int base;
        base = n_done_a + n_abort_a;
        for (int k = 0; k < budget && (n_done_a + n_abort_a) == base; k++) @(posedge clk);
        #1;
        check(tag, 64'((n_done_a + n_abort_a) != base), 64'd1);
    endtask

    initial begin
        int nd, na;
        for (int i = 0; i < 128; i++) begin
            mem_sv[i]  = VW'((i * 7 + 3) % 240);
            mem_sh[i]  = HW'((i * 13 + 5) % 320);
            mem_ev[i]  = VW'((i * 11 + 1) % 240);
            mem_eh[i]  = HW'((i * 5 + 9) % 320);
            mem_vld[i] = 1'b1;
        end
        first_a = -1; pops_a = 0;
        tick(2);
        check("reset_outs", 64'({busy_a, done_a, abort_a, ifa.m_valid, lines_a, raddr_a, ifa.m_index}), 64'd0);
        rst = 1'b0;
        tick(2);

        // Normal frame, consumer always ready
        start_a(5);
        wait_end_a("normal_end", 60);
        check("normal_done_cnt", 64'(n_done_a), 64'd1);
        check("normal_first_lat", 64'(first_a + 1 - t_a), 64'd3);
        check("normal_back2back", 64'(last_pop_a - first_pop_a), 64'd4);
        check("normal_done_lat", 64'(done_cyc_a - last_pop_a), 64'd2);
        check("normal_lines", 64'(lines_a), 64'd5);
        check("normal_sb_empty", 64'(qa.size()), 64'd0);
        tv_ready = 1'b0;
        tick(3);

        // Invalid entries 1 and 3: dropped by A, forwarded by B
        mem_vld[1] = 1'b0;
        mem_vld[3] = 1'b0;
        for (int i = 0; i < 5; i++) qb.push_back(exp_ent(i, mem_vld[i]));
        start_a(5);
        tv_ready_b = 1'b1;
        wait_end_a("skip_end", 60);
        for (int k = 0; k < 20 && n_done_b == 0; k++) @(posedge clk);
        #1;
        check("skip_b_done", 64'(n_done_b), 64'd1);
        check("skip_lines_a", 64'(lines_a), 64'd3);
        check("skip_lines_b", 64'(lines_b), 64'd5);
        check("skip_sb_empty", 64'(qa.size() + qb.size()), 64'd0);
        check("skip_b_idle", 64'(busy_b), 64'd0);
        mem_vld[1] = 1'b1;
        mem_vld[3] = 1'b1;
        tv_ready   = 1'b0;
        tv_ready_b = 1'b0;
        tick(3);

        // Backpressure: random ready plus a 10-cycle stall
        nd = n_done_a;
        start_a(8);
        for (int k = 0; k < 300 && n_done_a == nd; k++) begin
            if (k >= 5 && k < 15) rdy_a = 1'b0;
            else                  rdy_a = 1'($urandom_range(0, 1));
            tick(1);
        end
        rdy_a = 1'b1;
        check("bp_done", 64'(n_done_a - nd), 64'd1);
        check("bp_lines", 64'(lines_a), 64'd8);
        check("bp_sb_empty", 64'(qa.size()), 64'd0);
        tv_ready = 1'b0;
        tick(3);

        // Empty frame
        start_a(0);
        wait_end_a("empty_end", 20);
        check("empty_done_lat", 64'(done_cyc_a + 1 - t_a), 64'd2);
        check("empty_no_valid", 64'(first_a < 0), 64'd1);
        check("empty_lines", 64'(lines_a), 64'd0);
        tv_ready = 1'b0;
        tick(3);

        // Abort: tv_ready drops after 20 accepted segments
        nd = n_done_a; na = n_abort_a;
        start_a(100);
        for (int k = 0; k < 200 && pops_a < 20; k++) @(posedge clk);
        #1;
        tv_ready = 1'b0;
        wait_end_a("abort_end", 60);
        check("abort_pulse", 64'(n_abort_a - na), 64'd1);
        check("abort_no_done", 64'(n_done_a - nd), 64'd0);
        check("abort_pops_le22", 64'(pops_a <= 22 && pops_a >= 20), 64'd1);
        check("abort_lines", 64'(lines_a), 64'(pops_a));
        qa.delete();
        tick(3);

        // Reset in the middle of a frame, then a clean restart
        nd = n_done_a; na = n_abort_a;
        start_a(50);
        for (int k = 0; k < 200 && pops_a < 10; k++) @(posedge clk);
        #1;
        rst = 1'b1;
        tv_ready = 1'b0;
        #1;
        check("midrst_outs", 64'({busy_a, done_a, abort_a, ifa.m_valid, lines_a, raddr_a, ifa.m_index}), 64'd0);
        qa.delete();
        tick(2);
        rst = 1'b0;
        tick(3);
        check("midrst_no_pulse", 64'((n_done_a - nd) + (n_abort_a - na)), 64'd0);
        start_a(6);
        wait_end_a("restart_end", 60);
        check("restart_first_lat", 64'(first_a + 1 - t_a), 64'd3);
        check("restart_lines", 64'(lines_a), 64'd6);
        check("restart_sb_empty", 64'(qa.size()), 64'd0);
        check("b_never_aborted", 64'(n_abort_b), 64'd0);
        tv_ready = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/topview_line_reader.md
# topview_line_reader

Sequencer that drains the topview line-segment BRAM once per frame and streams the stored segments to a downstream consumer over a valid/ready handshake. It sits between the topview transform block and the path-planning logic. It watches the transform block's `ready`/`line_num` outputs, drives its `raddr` port, absorbs the 1-cycle BRAM read latency, and optionally drops entries whose valid bit is 0. Backpressure is handled with a credit-limited 2-entry output buffer, so no segment is lost or duplicated.

## Interface
- `OUT_HEIGHT`, default 240: topview image height; `V_W = $clog2(OUT_HEIGHT)`.
- `OUT_WIDTH`, default 320: topview image width; `H_W = $clog2(OUT_WIDTH)`.
- `ADDR_W`, default 12: BRAM address width, matching 4096 entries.
- `SKIP_INVALID`, default 1: when 1, entries with valid bit 0 are dropped. When 0, they are forwarded with `m_seg_valid = 0`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `tv_ready`  in  1  the frame's segment table is complete.
- `tv_line_num`  in  ADDR_W  number of stored entries.
- `tv_raddr`  out  ADDR_W  BRAM read address. Data appears on the `tv_*` inputs the cycle after the address is presented.
- `tv_start_v`, `tv_end_v`  in  V_W  BRAM read data.
- `tv_start_h`, `tv_end_h`  in  H_W  BRAM read data.
- `tv_valid`  in  1  BRAM read data, valid bit of the entry.
- `m_valid`  out  1  an output segment is available.
- `m_ready`  in  1  the consumer accepts the segment.
- `m_start_v`, `m_start_h`, `m_end_v`, `m_end_h`, `m_seg_valid`  out  segment fields, same widths as the BRAM fields.
- `m_index`  out  ADDR_W  BRAM address the segment came from.
- `busy`  out  1  a frame is in progress, or buffered entries have not been accepted yet.
- `frame_done`  out  1  1-cycle pulse when a frame completed normally.
- `frame_abort`  out  1  1-cycle pulse when a frame was cut short.
- `lines_out`  out  ADDR_W  number of segments accepted in the last frame. Held until the next frame starts.

## Operation
- **Start trigger.** A registered copy of `tv_ready` detects its rising edge. At the rising edge the block latches `tv_line_num` into `count`, clears `rd_addr` and the accepted counter, and goes IDLE→READ.
- **IDLE.** Rising edges of `tv_ready` that occur outside IDLE are ignored.
- **READ, issuing reads.** `tv_raddr = rd_addr`, driven combinationally from a register. A read issues in a cycle when both hold:
  - `rd_addr < count`;
  - `occ + inflight − pop < 2`.
- **READ, counter terms.**
  - `occ` is the buffer occupancy, 0..2.
  - `inflight` is 1 if a read issued in the previous cycle.
  - `pop = m_valid & m_ready`.
- **READ, returning data.** The cycle after an issue, the returning entry is pushed into the buffer tagged with its address. Exception: when `SKIP_INVALID=1` and `tv_valid=0`, the entry is discarded and not pushed.
- **READ→DRAIN.** Taken when the last read has been issued (`rd_addr == count`).
- **DRAIN→IDLE (normal end).** When `inflight=0` and `occ=0`, the block pulses `frame_done` and returns to IDLE.
- **Empty frame.** If `count = 0`, the block goes straight to DRAIN and `frame_done` pulses 2 cycles after the edge.
- **Abort.** If `tv_ready` falls during READ (the next frame is overwriting the BRAM):
  - no further reads issue;
  - the pending in-flight entry is still pushed;
  - entries already buffered are still delivered;
  - when the buffer empties, `frame_abort` pulses instead of `frame_done`.
- **Output buffer.** 2-entry FIFO with registered outputs.
  - `m_valid` and the data fields stay stable while `m_valid & !m_ready`.
  - The buffer never overflows, by construction of the issue rule. An assertion checks this.
- **`lines_out`.** Counts pops during the frame. It is copied to the output at `frame_done`/`frame_abort` and never wraps, because pops ≤ `count`.
- **`busy`.** Equals `state != IDLE`.
- **Reset values.** State IDLE; `tv_raddr`, `m_valid`, `m_*` fields, `m_index`, `busy`, `frame_done`, `frame_abort` and `lines_out` are all 0. The registered copy of `tv_ready` is 0, so a `tv_ready` that is high after reset counts as a rising edge.
- **Reset mid-frame.** The buffer is cleared immediately; no partial frame is resumed and no done or abort pulse is produced.

## Timing
- Rising edge of `tv_ready` sampled at edge t:
  - READ from t+1, first `tv_raddr` presented during t+1;
  - data captured at t+2;
  - first `m_valid` at t+3.
- With `m_ready` held high: 1 segment/cycle sustained; `frame_done` pulses 2 cycles after the last `m_valid & m_ready`.
- After a `m_ready` stall ends, `m_valid` does not drop; flow resumes 1/cycle with no bubble beyond the refill cycle.
- `frame_done` and `frame_abort` are mutually exclusive, never adjacent to each other, and each lasts exactly 1 cycle.

## Test plan
- **Normal frame.** `count=5`, all entries valid, `m_ready=1` → indices 0..4 on consecutive cycles, first at t+3; `frame_done` once; `lines_out=5`.
- **Skip invalid.** `SKIP_INVALID=1`, entries 1 and 3 invalid, `count=5` → indices 0, 2, 4 only; `lines_out=3`. With `SKIP_INVALID=0`, all 5 are emitted with `m_seg_valid = 1, 0, 1, 0, 1`.
- **Backpressure.** `count=8`, `m_ready` toggling randomly plus a 10-cycle stall → indices 0..7 in order, no duplicates; data stable during stalls; never more than 2 reads outstanding or buffered.
- **Abort.** `count=100`, `tv_ready` falls after 20 pops → remaining buffered entries (≤2) delivered; `frame_abort` pulse; `lines_out` ≤ 22; no `frame_done`.
- **Empty frame.** `tv_line_num=0` with a `tv_ready` rise → `frame_done` at t+2; `m_valid` never asserted.
- **Reset mid-frame.** `rst` pulsed mid-stream → all outputs 0 immediately. The next `tv_ready` rise restarts the frame from index 0.
